// File: rtl/ggt_pkg.sv
// ggt_pkg: shared FSM state type and mode encodings for the GCD engine.
package ggt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic MODE_EUCLID = 1'b0;
  localparam logic MODE_STEIN = 1'b1;
endpackage

// File: rtl/ggt_step.sv
// ggt_step: combinational single-step GCD datapath (Euclid or Stein rule).
// In:  a, b (operands), k (Stein shift count), mode (0 Euclid, 1 Stein).
// Out: a_nxt, b_nxt, k_nxt (next values), done (a or b is zero), res (final gcd).
module ggt_step
  import ggt_pkg::*;
#(
  parameter int W = 16,
  parameter int CW = 5
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [CW-1:0] k,
  input  logic          mode,
  output logic [W-1:0]  a_nxt,
  output logic [W-1:0]  b_nxt,
  output logic [CW-1:0] k_nxt,
  output logic          done,
  output logic [W-1:0]  res
);
  logic stein, ge, ea, eb;
  logic [W-1:0] base;
  always_comb begin
    stein = mode == MODE_STEIN;
    ge = a >= b;
    ea = ~a[0];
    eb = ~b[0];
    done = a == '0 || b == '0;
    base = a == '0 ? b : a;
    res = stein ? base << k : base;
    a_nxt = stein ? (ea ? a >> 1 : eb ? a : ge ? (a - b) >> 1 : a) : (ge ? a - b : a);
    b_nxt = stein ? (eb ? b >> 1 : ea ? b : ge ? b : (b - a) >> 1) : (ge ? b : b - a);
    k_nxt = stein && ea && eb ? k + CW'(1) : k;
  end
endmodule

// File: rtl/ggt_engine.sv
// ggt_engine: parametrised GCD engine (Euclid/Stein) with start/busy/valid handshake.
// In:  clk, rst_i (async, active-high), start_i, mode_i, Zahl1_i, Zahl2_i.
// Out: busy_o, valid_o, ergebnis_o, iter_o (step counter, only with GGT_ITER_CNT_EN).
module ggt_engine
  import ggt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [W-1:0] Zahl1_i,
  input  logic [W-1:0] Zahl2_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [W-1:0] ergebnis_o
`ifdef GGT_ITER_CNT_EN
  ,
  output logic [W-1:0] iter_o
`endif
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_nxt;
  logic [W-1:0] a, b, a_nxt, b_nxt, res;
  logic [CW-1:0] k, k_nxt;
  logic mode, done, accept;
  ggt_step #(.W(W), .CW(CW)) u_step (
    .a(a), .b(b), .k(k), .mode(mode),
    .a_nxt(a_nxt), .b_nxt(b_nxt), .k_nxt(k_nxt), .done(done), .res(res)
  );
  always_comb begin
    accept = start_i && state != CALC;
    state_nxt = accept ? CALC : (state == CALC && done) ? DONE : state;
  end
  // busy/valid are flops fed from the next state so they change on the same edge as state
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      busy_o <= state_nxt == CALC;
      valid_o <= state_nxt == DONE;
    end
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      a <= '0;
      b <= '0;
      k <= '0;
      mode <= MODE_EUCLID;
      ergebnis_o <= '0;
    end else if (accept) begin
      a <= Zahl1_i;
      b <= Zahl2_i;
      k <= '0;
      mode <= mode_i;
    end else if (state == CALC) begin
      if (done) ergebnis_o <= res;
      else begin
        a <= a_nxt;
        b <= b_nxt;
        k <= k_nxt;
      end
    end
  end
`ifdef GGT_ITER_CNT_EN
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) iter_o <= '0;
    else if (accept) iter_o <= '0;
    else if (state == CALC && !done) iter_o <= iter_o + W'(iter_o != '1);
  end
`endif
endmodule

// File: tb/tb_ggt_engine.sv
// tb_ggt_engine: randomized self-checking bench for ggt_engine against a gcd reference model.
module tb_ggt_engine;
  localparam int W = 16;
  localparam logic [W-1:0] MAXV = '1;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic mode_i = 1'b0;
  logic [W-1:0] Zahl1_i = '0;
  logic [W-1:0] Zahl2_i = '0;
  logic busy_o, valid_o;
  logic [W-1:0] ergebnis_o;
`ifdef GGT_ITER_CNT_EN
  logic [W-1:0] iter_o;
`endif
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ggt_engine #(.W(W)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i),
    .busy_o(busy_o), .valid_o(valid_o), .ergebnis_o(ergebnis_o)
`ifdef GGT_ITER_CNT_EN
    , .iter_o(iter_o)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint gcd_ref(input longint x, input longint y);
    longint t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  // subtractive Euclid takes exactly the sum of the division quotients
  function automatic longint eu_steps(input longint x, input longint y);
    longint s, t;
    s = 0;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return s;
  endfunction
  function automatic longint st_steps(input longint x, input longint y);
    longint s;
    s = 0;
    while (x != 0 && y != 0) begin
      s++;
      if (x % 2 == 0 && y % 2 == 0) begin
        x /= 2;
        y /= 2;
      end else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x >= y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return s;
  endfunction
  // entered and left at a negedge; consecutive calls are therefore back-to-back
  task automatic run(input logic m, input logic [W-1:0] z1, input logic [W-1:0] z2,
                     input longint eg, input longint es, input bit poke);
    longint n;
    mode_i = m;
    Zahl1_i = z1;
    Zahl2_i = z2;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_accept", busy_o, 1);
    check("valid_after_accept", valid_o, 0);
    n = 0;
    while (!valid_o && n < es + 20) begin
      start_i = poke && n == 1;
      if (poke && n == 1) begin
        Zahl1_i = 7;
        Zahl2_i = 5;
        mode_i = ~m;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start_i = 1'b0;
    check("latency", n, es + 1);
    check("result", ergebnis_o, eg);
    check("busy_done", busy_o, 0);
`ifdef GGT_ITER_CNT_EN
    check("iter", iter_o, es > longint'(MAXV) ? longint'(MAXV) : es);
`endif
  endtask
  initial begin
    logic [W-1:0] x, y;
    int sh;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_result", ergebnis_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    run(0, 12, 18, 6, 3, 0);
    run(1, 12, 18, 6, 4, 0);
    run(1, 48, 180, 12, 8, 0);
    for (int m = 0; m < 2; m++) begin
      run(m[0], 0, 0, 0, 0, 0);
      run(m[0], 0, 35, 35, 0, 0);
      run(m[0], 35, 0, 35, 0, 0);
    end
    run(0, 12, 18, 6, 3, 1);
    mode_i = 1'b1;
    Zahl1_i = 48;
    Zahl2_i = 180;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_result", ergebnis_o, 0);
`ifdef GGT_ITER_CNT_EN
    check("arst_iter", iter_o, 0);
`endif
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    run(1, 12, 18, 6, 4, 0);
    for (int i = 0; i < 200; i++) begin
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) x = '0;
      if ($urandom_range(0, 19) == 0) y = '0;
      run(0, x, y, gcd_ref(x, y), eu_steps(x, y), 0);
    end
    for (int i = 0; i < 200; i++) begin
      sh = $urandom_range(0, 3);
      x = W'($urandom) << sh;
      y = W'($urandom) << sh;
      if ($urandom_range(0, 19) == 0) x = '0;
      if ($urandom_range(0, 19) == 0) y = '0;
      run(1, x, y, gcd_ref(x, y), st_steps(x, y), 0);
    end
    run(0, 1, MAXV, 1, longint'(MAXV), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
